// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
// Holds the state encoding and the word-address range check.
package mem_arbiter_pkg;

  localparam int MEM_DEPTH_DEF  = 1024;
  localparam int WORD_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // A word occupies addr and addr+1, so the last legal word starts at depth-2.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr <= 32'(depth - 2);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: returns a one-hot winner, prio breaks ties.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = prio ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer serialising fetch (port 0) and load/store
// (port 1) accesses onto a single-port byte memory with fixed read latency.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [WORD_WIDTH-1:0] wdata0,
  input  logic [WORD_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [WORD_WIDTH-1:0] rdata0,
  output logic [WORD_WIDTH-1:0] rdata1,
  output logic                  err0,
  output logic                  err1,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_wr_en,
  output logic [WORD_WIDTH-1:0] mem_data_in,
  input  logic [WORD_WIDTH-1:0] mem_data_out
);

  localparam logic [1:0] CNT_INIT = (READ_LAT > 0) ? 2'(READ_LAT - 1) : 2'd0;

  arb_state_t state_reg, state_next;
  logic       prio_reg;
  logic       owner_reg;
  logic       we_reg;
  logic       ok_reg;
  logic [1:0] cnt_reg;

  logic [1:0]            win;
  logic                  win_sel;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic [WORD_WIDTH-1:0] wdata_w;
  logic                  we_w;
  logic                  ok_w;
  logic                  capture;
  logic                  err_done;

  rr_arb2 u_pick (
    .req  ({req1, req0}),
    .prio (prio_reg),
    .gnt  (win)
  );

  assign win_sel = win[1];
  assign addr_w  = win_sel ? addr1  : addr0;
  assign wdata_w = win_sel ? wdata1 : wdata0;
  assign we_w    = win_sel ? we1    : we0;
  assign ok_w    = addr_in_range(32'(addr_w), MEM_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    err_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|win) state_next = ISSUE;
      end
      ISSUE: begin
        if (we_reg || !ok_reg) begin
          err_done   = !ok_reg;
          state_next = IDLE;
        end else if (READ_LAT == 0) begin
          capture    = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == 2'd0) begin
          capture    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_reg    <= 1'b0;
      owner_reg   <= 1'b0;
      we_reg      <= 1'b0;
      ok_reg      <= 1'b0;
      cnt_reg     <= 2'd0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      mem_address <= '0;
      mem_wr_en   <= 1'b0;
      mem_data_in <= '0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      mem_wr_en <= 1'b0;

      if (state_reg == IDLE && |win) begin
        mem_address <= addr_w;
        mem_data_in <= wdata_w;
        mem_wr_en   <= we_w & ok_w;
        gnt0        <= win[0];
        gnt1        <= win[1];
        prio_reg    <= !win_sel;
        owner_reg   <= win_sel;
        we_reg      <= we_w;
        ok_reg      <= ok_w;
      end

      if (state_reg == ISSUE) begin
        cnt_reg <= CNT_INIT;
      end else if (state_reg == WAIT && cnt_reg != 2'd0) begin
        cnt_reg <= cnt_reg - 2'd1;
      end

      // Rejected writes report an error but leave the held read data alone.
      if (capture || err_done) begin
        if (owner_reg) begin
          rvalid1 <= 1'b1;
          err1    <= err_done;
          if (capture)      rdata1 <= mem_data_out;
          else if (!we_reg) rdata1 <= '0;
        end else begin
          rvalid0 <= 1'b1;
          err0    <= err_done;
          if (capture)      rdata0 <= mem_data_out;
          else if (!we_reg) rdata0 <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (READ_LAT 1, 0, 3) share one stimulus,
// each with its own byte-memory model; read returns are checked from a scoreboard.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;

  logic        gnt0_a [3], gnt1_a [3], rvalid0_a [3], rvalid1_a [3];
  logic        err0_a [3], err1_a [3], mem_wr_en_a [3];
  logic [15:0] rdata0_a [3], rdata1_a [3], mem_address_a [3], mem_data_in_a [3], mdo_a [3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          inst;
    int          port;
    logic        err;
    logic        chk_data;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  logic [7:0] ref_mem [0:1023];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
    logic [7:0]  mem_b [0:1023];
    logic [15:0] pipe [0:3];
    logic [15:0] rd_now;
    logic [9:0]  a_lo, a_hi;

    mem_arbiter #(.READ_LAT(L)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0         (req0),
      .req1         (req1),
      .we0          (we0),
      .we1          (we1),
      .addr0        (addr0),
      .addr1        (addr1),
      .wdata0       (wdata0),
      .wdata1       (wdata1),
      .gnt0         (gnt0_a[gi]),
      .gnt1         (gnt1_a[gi]),
      .rvalid0      (rvalid0_a[gi]),
      .rvalid1      (rvalid1_a[gi]),
      .rdata0       (rdata0_a[gi]),
      .rdata1       (rdata1_a[gi]),
      .err0         (err0_a[gi]),
      .err1         (err1_a[gi]),
      .mem_address  (mem_address_a[gi]),
      .mem_wr_en    (mem_wr_en_a[gi]),
      .mem_data_in  (mem_data_in_a[gi]),
      .mem_data_out (mdo_a[gi])
    );

    assign a_lo = mem_address_a[gi][9:0];
    assign a_hi = a_lo + 10'd1;
    always_comb rd_now = (mem_address_a[gi] <= 16'd1022) ? {mem_b[a_hi], mem_b[a_lo]} : 16'h0000;

    always @(posedge clk) begin
      if (mem_wr_en_a[gi] && mem_address_a[gi] <= 16'd1022) begin
        mem_b[a_lo] <= mem_data_in_a[gi][7:0];
        mem_b[a_hi] <= mem_data_in_a[gi][15:8];
      end
      pipe[0] <= rd_now;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end

    if (L == 0) begin : g_l0
      assign mdo_a[gi] = rd_now;
    end else begin : g_lx
      assign mdo_a[gi] = pipe[L-1];
    end
  end

  // Scoreboard consumer: every rvalid must match the oldest expectation for its instance/port.
  always @(negedge clk) begin
    logic        rv, er;
    logic [15:0] rd;
    int          idx;
    exp_t        e;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        for (int p = 0; p < 2; p++) begin
          rv = (p == 1) ? rvalid1_a[i] : rvalid0_a[i];
          er = (p == 1) ? err1_a[i]    : err0_a[i];
          rd = (p == 1) ? rdata1_a[i]  : rdata0_a[i];
          if (rv) begin
            idx = -1;
            for (int k = 0; k < sbq.size(); k++)
              if (idx < 0 && sbq[k].inst == i && sbq[k].port == p) idx = k;
            chk($sformatf("sb_match i%0d p%0d", i, p), 32'(idx >= 0), 32'd1);
            if (idx >= 0) begin
              e = sbq[idx];
              sbq.delete(idx);
              chk($sformatf("rvalid_cycle i%0d p%0d", i, p), 32'(cyc), 32'(e.due));
              chk($sformatf("err i%0d p%0d", i, p), 32'(er), 32'(e.err));
              if (e.chk_data) chk($sformatf("rdata i%0d p%0d", i, p), 32'(rd), 32'(e.data));
              $display("rvalid inst=%0d port=%0d cyc=%0d err=%0b rdata=%04h", i, p, cyc, er, rd);
            end
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_ctl i%0d", tag, i),
          32'({gnt0_a[i], gnt1_a[i], rvalid0_a[i], rvalid1_a[i], err0_a[i], err1_a[i], mem_wr_en_a[i]}), 32'd0);
      chk($sformatf("%s_data i%0d", tag, i),
          32'(rdata0_a[i] | rdata1_a[i] | mem_address_a[i] | mem_data_in_a[i]), 32'd0);
    end
  endtask

  task automatic access(input int p, input logic we, input logic [15:0] a, input logic [15:0] d);
    logic        ok;
    logic [15:0] exp_d;
    int          c;
    ok = (a <= 16'd1022);
    if (p == 1) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    else        begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    @(negedge clk);
    c = cyc;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("gnt_own i%0d", i), 32'((p == 1) ? gnt1_a[i] : gnt0_a[i]), 32'd1);
      chk($sformatf("gnt_other i%0d", i), 32'((p == 1) ? gnt0_a[i] : gnt1_a[i]), 32'd0);
    end
    chk("mem_address", 32'(mem_address_a[0]), 32'(a));
    chk("mem_wr_en_c", 32'(mem_wr_en_a[0]), 32'(we & ok));
    if (we && ok) chk("mem_data_in", 32'(mem_data_in_a[0]), 32'(d));
    exp_d = (ok && !we) ? {ref_mem[a[9:0] + 10'd1], ref_mem[a[9:0]]} : 16'h0000;
    if (we && ok) begin
      ref_mem[a[9:0]]         = d[7:0];
      ref_mem[a[9:0] + 10'd1] = d[15:8];
    end
    if (!ok || !we)
      for (int i = 0; i < 3; i++)
        sbq.push_back('{inst: i, port: p, err: !ok, chk_data: !we, data: exp_d,
                        due: c + (ok ? lat_of(i) + 1 : 1)});
    $display("access port=%0d we=%0b addr=%04h wdata=%04h C=%0d", p, we, a, d, c);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    chk("mem_wr_en_c1", 32'(mem_wr_en_a[0]), 32'd0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int seq[$];
    int c;

    repeat (2) @(negedge clk);
    check_all_zero("reset");

    // Both requesters held across reset release: grants must alternate starting at port 0.
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'hA5A5;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0020; wdata1 = 16'h5A5A;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("no_dual_gnt", 32'(gnt0_a[0] & gnt1_a[0]), 32'd0);
      if (gnt0_a[0]) seq.push_back(0);
      if (gnt1_a[0]) seq.push_back(1);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    ref_mem[10'h010] = 8'hA5; ref_mem[10'h011] = 8'hA5;
    ref_mem[10'h020] = 8'h5A; ref_mem[10'h021] = 8'h5A;
    chk("contention_count", 32'(seq.size()), 32'd4);
    for (int k = 0; k < seq.size(); k++) chk($sformatf("contention_order %0d", k), 32'(seq[k]), 32'(k % 2));
    $display("contention grants=%0d", seq.size());
    repeat (5) @(negedge clk);

    access(0, 1'b1, 16'h0000, 16'h0001);
    access(1, 1'b0, 16'h0000, 16'h0000);
    access(1, 1'b0, 16'h0010, 16'h0000);
    access(0, 1'b0, 16'h0020, 16'h0000);
    access(1, 1'b1, 16'd1022, 16'hBEEF);
    access(0, 1'b1, 16'd1023, 16'hDEAD);
    access(0, 1'b0, 16'd1022, 16'h0000);
    access(1, 1'b0, 16'hFFFF, 16'h0000);
    access(0, 1'b1, 16'h0100, 16'h1234);
    access(1, 1'b0, 16'h0100, 16'h0000);

    // Reset during the wait phase of a read: LAT0 instance already returned, others must drop it.
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0100;
    @(negedge clk);
    c = cyc;
    chk("rst_wait_gnt", 32'(gnt0_a[0]), 32'd1);
    sbq.push_back('{inst: 1, port: 0, err: 1'b0, chk_data: 1'b1, data: 16'h1234, due: c + 1});
    req0 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    $display("reset_in_wait released cyc=%0d", cyc);

    // prio must be back at 0: simultaneous requests grant port 0.
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0000;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010;
    @(negedge clk);
    c = cyc;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("prio_gnt0 i%0d", i), 32'(gnt0_a[i]), 32'd1);
      chk($sformatf("prio_gnt1 i%0d", i), 32'(gnt1_a[i]), 32'd0);
      sbq.push_back('{inst: i, port: 0, err: 1'b0, chk_data: 1'b1, data: 16'h0001, due: c + lat_of(i) + 1});
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (8) @(negedge clk);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
